// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the program counter, issues word fetches over a
// req/ready handshake and feeds decode through a two-entry output buffer
// (entry 0 is the output register, entry 1 is the skid entry). Taken
// branches/jumps flush the buffer and squash any wrong-path fetch, including
// one still outstanding at the memory.
module fetch_sequencer #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] pc
);

  typedef enum logic [1:0] {
    RST_WAIT = 2'd0,
    RUN      = 2'd1,
    DRAIN    = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] tgt_q, tgt_d;
  logic [1:0]  occ_q, occ_d, occ_c;
  logic [31:0] b0_inst_q, b0_inst_d, b0_pc_q, b0_pc_d;
  logic [31:0] b1_inst_q, b1_inst_d, b1_pc_q, b1_pc_d;

  logic        consume;
  logic        fetch_done;
  logic [31:0] redir_addr;

  // All outputs come straight from state registers; no input reaches them
  // combinationally. While draining, pc_q still holds the outstanding
  // address, so imem_addr and pc both show it until the old beat returns.
  assign pc         = pc_q;
  assign imem_addr  = pc_q;
  assign inst       = b0_inst_q;
  assign inst_pc    = b0_pc_q;
  assign inst_valid = (occ_q != 2'd0);
  assign imem_req   = (state_q == DRAIN) || ((state_q == RUN) && (occ_q != 2'd2));

  assign consume    = inst_valid && !stall;
  assign fetch_done = imem_req && imem_ready;
  assign redir_addr = redirect_target & 32'hFFFF_FFFC;

  // Next-state: sequencer state, pc/held target, and buffer occupancy/data.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    tgt_d     = tgt_q;
    occ_d     = occ_q;
    occ_c     = occ_q;
    b0_inst_d = b0_inst_q;
    b0_pc_d   = b0_pc_q;
    b1_inst_d = b1_inst_q;
    b1_pc_d   = b1_pc_q;

    case (state_q)
      RST_WAIT: begin
        state_d = RUN;
        if (redirect_valid) pc_d = redir_addr;
      end

      RUN: begin
        if (redirect_valid) begin
          occ_d = '0;
          if (imem_req && !imem_ready) begin
            // Request cannot be aborted: park the target until it completes.
            state_d = DRAIN;
            tgt_d   = redir_addr;
          end else begin
            pc_d = redir_addr;
          end
        end else begin
          // Consume first, then the returning word lands in the first free slot.
          occ_c = occ_q - {1'b0, consume};
          if (consume && (occ_q == 2'd2)) begin
            b0_inst_d = b1_inst_q;
            b0_pc_d   = b1_pc_q;
          end
          if (fetch_done) begin
            if (occ_c == 2'd0) begin
              b0_inst_d = imem_rdata;
              b0_pc_d   = pc_q;
            end else begin
              b1_inst_d = imem_rdata;
              b1_pc_d   = pc_q;
            end
            pc_d = pc_q + 32'd4;
          end
          occ_d = occ_c + {1'b0, fetch_done};
        end
      end

      DRAIN: begin
        occ_d = '0;
        if (redirect_valid) tgt_d = redir_addr;
        if (imem_ready) begin
          state_d = RUN;
          pc_d    = redirect_valid ? redir_addr : tgt_q;
        end
      end

      default: state_d = RST_WAIT;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= RST_WAIT;
      pc_q      <= RESET_ADDR;
      tgt_q     <= '0;
      occ_q     <= '0;
      b0_inst_q <= '0;
      b0_pc_q   <= '0;
      b1_inst_q <= '0;
      b1_pc_q   <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      tgt_q     <= tgt_d;
      occ_q     <= occ_d;
      b0_inst_q <= b0_inst_d;
      b0_pc_q   <= b0_pc_d;
      b1_inst_q <= b1_inst_d;
      b1_pc_q   <= b1_pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus a
// randomized run checked against an instruction-stream reference model.
module tb_fetch_sequencer;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        imem_ready = 1'b0;

  logic        imem_req, inst_valid;
  logic [31:0] imem_addr, imem_rdata, inst, inst_pc, pc;

  logic        w_req, w_valid;
  logic [31:0] w_addr, w_rdata, w_inst, w_inst_pc, w_pc;

  int checks = 0;
  int failures = 0;

  // Memory content: a distinct, address-derived word for every location.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, a[31:16] ^ 16'hC3A5};
  endfunction

  assign imem_rdata = word_at(imem_addr);
  assign w_rdata    = word_at(w_addr);

  fetch_sequencer dut (
    .clock(clock), .reset_n(reset_n), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .inst_valid(inst_valid), .inst(inst),
    .inst_pc(inst_pc), .pc(pc)
  );

  fetch_sequencer #(.RESET_ADDR(32'hFFFF_FFF8)) dut_wrap (
    .clock(clock), .reset_n(reset_n), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .imem_req(w_req), .imem_addr(w_addr), .imem_ready(imem_ready),
    .imem_rdata(w_rdata), .inst_valid(w_valid), .inst(w_inst),
    .inst_pc(w_inst_pc), .pc(w_pc)
  );

  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = '0;
    imem_ready = 1'b0;
    repeat (3) step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    stall = 1'b0;
    redirect_valid = 1'b0;
    imem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({imem_req, inst_valid, pc, imem_addr, inst, inst_pc} !== {2'b00, 128'h0}) begin
        failures++;
        $display("FAIL reset_state cyc%0d: got req=%b val=%b pc=%h addr=%h inst=%h ipc=%h want all zero",
                 i, imem_req, inst_valid, pc, imem_addr, inst, inst_pc);
      end
    end
    reset_n = 1'b1;
    step();
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
      failures++;
      $display("FAIL first_request: got req=%b addr=%h want req=1 addr=00000000", imem_req, imem_addr);
    end
    for (int i = 0; i < 4; i++) begin
      logic [31:0] e;
      e = 32'(4 * i);
      step();
      checks++;
      if ({inst_valid, inst_pc, inst} !== {1'b1, e, word_at(e)}) begin
        failures++;
        $display("FAIL boot_stream %0d: got val=%b ipc=%h inst=%h want val=1 ipc=%h inst=%h",
                 i, inst_valid, inst_pc, inst, e, word_at(e));
      end
    end
  endtask

  task automatic test_wait_states();
    int d;
    logic req0, rdy0;
    logic [31:0] addr0, e;
    d = 0;
    do_reset();
    step();
    for (int k = 0; k < 15; k++) begin
      imem_ready = ((k % 3) == 2);
      req0 = imem_req;
      addr0 = imem_addr;
      rdy0 = imem_ready;
      step();
      if (req0 && !rdy0) begin
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, addr0}) begin
          failures++;
          $display("FAIL wait_hold k=%0d: got req=%b addr=%h want req=1 addr=%h", k, imem_req, imem_addr, addr0);
        end
      end
      if (inst_valid) begin
        e = 32'(4 * d);
        checks++;
        if ({inst_pc, inst} !== {e, word_at(e)}) begin
          failures++;
          $display("FAIL wait_data %0d: got ipc=%h inst=%h want ipc=%h inst=%h", d, inst_pc, inst, e, word_at(e));
        end
        d++;
      end
    end
    checks++;
    if (d != 5) begin
      failures++;
      $display("FAIL wait_pulses: got %0d want 5", d);
    end
  endtask

  task automatic test_stall_skid();
    bit found;
    logic [31:0] e;
    found = 0;
    do_reset();
    step();
    imem_ready = 1'b1;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (inst_valid && inst_pc == 32'h8) found = 1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL skid_reach8: got timeout want inst_pc=00000008");
      return;
    end
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if ({inst_valid, inst_pc, inst, imem_req} !== {1'b1, 32'h8, word_at(32'h8), 1'b0}) begin
        failures++;
        $display("FAIL skid_hold %0d: got val=%b ipc=%h req=%b want val=1 ipc=00000008 req=0",
                 i, inst_valid, inst_pc, imem_req);
      end
    end
    stall = 1'b0;
    for (int i = 0; i < 3; i++) begin
      e = 32'hC + 32'(4 * i);
      step();
      checks++;
      if ({inst_valid, inst_pc, inst} !== {1'b1, e, word_at(e)}) begin
        failures++;
        $display("FAIL skid_release %0d: got val=%b ipc=%h inst=%h want val=1 ipc=%h inst=%h",
                 i, inst_valid, inst_pc, inst, e, word_at(e));
      end
      if (i == 0) begin
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h10}) begin
          failures++;
          $display("FAIL skid_rereq: got req=%b addr=%h want req=1 addr=00000010", imem_req, imem_addr);
        end
      end
    end
  endtask

  task automatic test_redirect_inflight();
    bit found;
    found = 0;
    do_reset();
    step();
    imem_ready = 1'b1;
    for (int i = 0; i < 12 && !found; i++) begin
      step();
      if (imem_req && imem_addr == 32'h10) found = 1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL inflight_reach: got timeout want req at 00000010");
      return;
    end
    imem_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_target = 32'h40;
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (i == 1) step();
      checks++;
      if ({imem_req, imem_addr, pc, inst_valid} !== {1'b1, 32'h10, 32'h10, 1'b0}) begin
        failures++;
        $display("FAIL drain_hold %0d: got req=%b addr=%h pc=%h val=%b want req=1 addr=00000010 pc=00000010 val=0",
                 i, imem_req, imem_addr, pc, inst_valid);
      end
    end
    imem_ready = 1'b1;
    step();
    checks++;
    if ({imem_req, imem_addr, pc, inst_valid} !== {1'b1, 32'h40, 32'h40, 1'b0}) begin
      failures++;
      $display("FAIL drain_exit: got req=%b addr=%h pc=%h val=%b want req=1 addr=00000040 pc=00000040 val=0",
               imem_req, imem_addr, pc, inst_valid);
    end
    step();
    checks++;
    if ({inst_valid, inst_pc, inst} !== {1'b1, 32'h40, word_at(32'h40)}) begin
      failures++;
      $display("FAIL drain_target: got val=%b ipc=%h inst=%h want val=1 ipc=00000040 inst=%h",
               inst_valid, inst_pc, inst, word_at(32'h40));
    end
  endtask

  task automatic test_redirect_stall_ready();
    bit found;
    found = 0;
    do_reset();
    step();
    imem_ready = 1'b1;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (inst_valid && inst_pc == 32'h8) found = 1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL rsr_reach8: got timeout want inst_pc=00000008");
      return;
    end
    stall = 1'b1;
    step();
    step();
    checks++;
    if ({imem_req, inst_valid, inst_pc} !== {1'b0, 1'b1, 32'h8}) begin
      failures++;
      $display("FAIL rsr_full: got req=%b val=%b ipc=%h want req=0 val=1 ipc=00000008", imem_req, inst_valid, inst_pc);
    end
    redirect_valid = 1'b1;
    redirect_target = 32'h201;
    step();
    redirect_valid = 1'b0;
    checks++;
    if ({inst_valid, pc, imem_addr, imem_req} !== {1'b0, 32'h200, 32'h200, 1'b1}) begin
      failures++;
      $display("FAIL rsr_flush_full: got val=%b pc=%h addr=%h req=%b want val=0 pc=00000200 addr=00000200 req=1",
               inst_valid, pc, imem_addr, imem_req);
    end
    step();
    checks++;
    if ({inst_valid, inst_pc, imem_req, imem_addr} !== {1'b1, 32'h200, 1'b1, 32'h204}) begin
      failures++;
      $display("FAIL rsr_refill: got val=%b ipc=%h req=%b addr=%h want val=1 ipc=00000200 req=1 addr=00000204",
               inst_valid, inst_pc, imem_req, imem_addr);
    end
    redirect_valid = 1'b1;
    redirect_target = 32'h101;
    step();
    redirect_valid = 1'b0;
    checks++;
    if ({inst_valid, pc, imem_addr, imem_req} !== {1'b0, 32'h100, 32'h100, 1'b1}) begin
      failures++;
      $display("FAIL rsr_same_edge: got val=%b pc=%h addr=%h req=%b want val=0 pc=00000100 addr=00000100 req=1",
               inst_valid, pc, imem_addr, imem_req);
    end
    step();
    checks++;
    if ({inst_valid, inst_pc, inst} !== {1'b1, 32'h100, word_at(32'h100)}) begin
      failures++;
      $display("FAIL rsr_target: got val=%b ipc=%h inst=%h want val=1 ipc=00000100 inst=%h",
               inst_valid, inst_pc, inst, word_at(32'h100));
    end
    stall = 1'b0;
  endtask

  // Reference model: decode must see a run of consecutive word addresses
  // starting at the last redirect target, each carrying that address's word.
  task automatic test_random();
    logic [31:0] exp_pc, addr0;
    logic req0, rdy0;
    int delivered;
    delivered = 0;
    exp_pc = 32'h0;
    do_reset();
    step();
    for (int c = 0; c < 600; c++) begin
      stall = ($urandom_range(9) < 3);
      imem_ready = $urandom_range(1) == 1;
      redirect_valid = ($urandom_range(24) == 0);
      redirect_target = $urandom & 32'h0000_0FFF;
      req0 = imem_req;
      addr0 = imem_addr;
      rdy0 = imem_ready;
      if (redirect_valid) begin
        exp_pc = redirect_target & 32'hFFFF_FFFC;
      end else if (inst_valid && !stall) begin
        checks++;
        if ({inst_pc, inst} !== {exp_pc, word_at(exp_pc)}) begin
          failures++;
          $display("FAIL rand_stream c=%0d: got ipc=%h inst=%h want ipc=%h inst=%h",
                   c, inst_pc, inst, exp_pc, word_at(exp_pc));
        end
        exp_pc = exp_pc + 32'd4;
        delivered++;
      end
      step();
      if (req0 && !rdy0) begin
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, addr0}) begin
          failures++;
          $display("FAIL rand_handshake c=%0d: got req=%b addr=%h want req=1 addr=%h", c, imem_req, imem_addr, addr0);
        end
      end
    end
    redirect_valid = 1'b0;
    stall = 1'b0;
    checks++;
    if (delivered < 40) begin
      failures++;
      $display("FAIL rand_progress: got %0d delivered want at least 40", delivered);
    end
  endtask

  task automatic test_wrap_async();
    logic [31:0] e;
    do_reset();
    step();
    imem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      e = 32'hFFFF_FFF8 + 32'(4 * i);
      step();
      checks++;
      if ({w_valid, w_inst_pc, w_inst} !== {1'b1, e, word_at(e)}) begin
        failures++;
        $display("FAIL wrap_stream %0d: got val=%b ipc=%h inst=%h want val=1 ipc=%h inst=%h",
                 i, w_valid, w_inst_pc, w_inst, e, word_at(e));
      end
    end
    imem_ready = 1'b0;
    step();
    step();
    checks++;
    if (w_req !== 1'b1) begin
      failures++;
      $display("FAIL wrap_pending: got req=%b want req=1", w_req);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({w_req, w_valid, w_pc, w_addr, w_inst, w_inst_pc} !==
        {2'b00, 32'hFFFF_FFF8, 32'hFFFF_FFF8, 64'h0}) begin
      failures++;
      $display("FAIL async_reset_wrap: got req=%b val=%b pc=%h addr=%h inst=%h ipc=%h want 0 0 fffffff8 fffffff8 0 0",
               w_req, w_valid, w_pc, w_addr, w_inst, w_inst_pc);
    end
    checks++;
    if ({imem_req, inst_valid, pc, imem_addr, inst, inst_pc} !== {2'b00, 128'h0}) begin
      failures++;
      $display("FAIL async_reset_main: got req=%b val=%b pc=%h addr=%h inst=%h ipc=%h want all zero",
               imem_req, inst_valid, pc, imem_addr, inst, inst_pc);
    end
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_wait_states();
    test_stall_skid();
    test_redirect_inflight();
    test_redirect_stall_ready();
    test_random();
    test_wrap_async();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
